// File: rtl/fp_div_seq.sv
// Sequential radix-2 restoring floating-point divider: result = value1 / value2.
// Define FP_DIV_FLAGS_EN to add the {invalid, divzero, overflow, underflow} flags port.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] value1,
  input  logic [EXP_W+MAN_W:0] value2,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FP_DIV_FLAGS_EN
  output logic [3:0]           flags,
`endif
  output logic [EXP_W+MAN_W:0] result
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int RW = MAN_W + 2;
  localparam int QW = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic signed [EW-1:0] MAXE_S = EW'((2**EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic                 s1, s2, sgn;
  logic [EXP_W-1:0]     e1, e2;
  logic [MAN_W-1:0]     f1, f2;
  logic                 zero1, zero2, inf1, inf2, nan1, nan2;
  logic                 invalid_op, special, accept;
  logic [W-1:0]         spec_res;

  logic [RW-1:0]        rem;
  logic [MW-1:0]        m2;
  logic [QW-1:0]        q;
  logic signed [EW-1:0] exp_r;
  logic                 sgn_r;

  logic signed [EW-1:0] rnd_e;
  logic [MAN_W-1:0]     rnd_m;
  logic                 rnd_ovf, rnd_unf;
  logic [W-1:0]         rnd_res;

  // Normalise the raw quotient, round to nearest even, and return {exponent, stored mantissa}.
  function automatic logic [EW+MAN_W-1:0] norm_round(input logic signed [EW-1:0] e_in,
                                                     input logic [QW-1:0] q_in,
                                                     input logic rem_nz);
    logic [QW-1:0]        qn;
    logic signed [EW-1:0] e;
    logic [MW:0]          m;
    logic                 rb, st;
    if (q_in[QW-1]) begin
      qn = q_in;
      e  = e_in;
    end else begin
      qn = q_in << 1;
      e  = e_in - ONE_S;
    end
    m  = {1'b0, qn[QW-1 -: MW]};
    rb = qn[1];
    st = qn[0] | rem_nz;
    if (rb && (st || m[0])) m = m + 1'b1;
    if (m[MW]) begin
      m = m >> 1;
      e = e + ONE_S;
    end
    return {e, m[MAN_W-1:0]};
  endfunction

  assign {s1, e1, f1} = value1;
  assign {s2, e2, f2} = value2;
  assign sgn   = s1 ^ s2;
  // Subnormals are flushed, so a zero exponent means zero regardless of the fraction.
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign inf1  = (&e1) && (f1 == '0);
  assign inf2  = (&e2) && (f2 == '0);
  assign nan1  = (&e1) && (f1 != '0);
  assign nan2  = (&e2) && (f2 != '0);
  assign invalid_op = nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2);

  always_comb begin
    special  = 1'b1;
    spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (invalid_op)          spec_res = QNAN;
    else if (zero2 || inf1)  spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero1 || inf2)  spec_res = {sgn, {(EXP_W+MAN_W){1'b0}}};
    else                     special  = 1'b0;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)     cnt <= '0;
      else if (state == DIV) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : DIV;
      DIV:     if (cnt == CW'(QW-1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, then one restoring quotient bit per DIV cycle
  always_ff @(posedge aclk) begin
    if (accept) begin
      rem   <= {1'b0, 1'b1, f1};
      m2    <= {1'b1, f2};
      q     <= '0;
      exp_r <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS_S;
      sgn_r <= sgn;
    end else if (state == DIV) begin
      if (rem >= {1'b0, m2}) begin
        rem <= (rem - {1'b0, m2}) << 1;
        q   <= {q[QW-2:0], 1'b1};
      end else begin
        rem <= rem << 1;
        q   <= {q[QW-2:0], 1'b0};
      end
    end
  end

  // Round and range-check the finished quotient
  assign {rnd_e, rnd_m} = norm_round(exp_r, q, |rem);
  assign rnd_ovf = (rnd_e >= MAXE_S);
  assign rnd_unf = (rnd_e <= ZERO_S);

  always_comb begin
    if (rnd_ovf)      rnd_res = {sgn_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (rnd_unf) rnd_res = {sgn_r, {(EXP_W+MAN_W){1'b0}}};
    else              rnd_res = {sgn_r, rnd_e[EXP_W-1:0], rnd_m};
  end

  always_ff @(posedge aclk) begin
    if (areset)                result <= '0;
    else if (accept && special) result <= spec_res;
    else if (state == ROUND)    result <= rnd_res;
  end

`ifdef FP_DIV_FLAGS_EN
  logic [3:0] spec_flags;

  always_comb begin
    spec_flags = '0;
    if (invalid_op)            spec_flags[3] = 1'b1;
    else if (zero2 && !inf1)   spec_flags[2] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset)                         flags <= '0;
    else if (accept && special)         flags <= spec_flags;
    else if (state == ROUND)            flags <= {2'b00, rnd_ovf, rnd_unf && !rnd_ovf};
    else if (out_valid && out_ready)    flags <= '0;
  end
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed cases from the plan plus randomized operands
// checked against an integer-division reference model.
module tb_fp_div_seq;

  logic        aclk;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value1;
  logic [31:0] value2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  fp_div_seq dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value1    (value1),
    .value2    (value2),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP_DIV_FLAGS_EN
    .flags     (flags),
`endif
    .result    (result)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: specials from the classification rules, normals via one wide integer division.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    logic s, za, zb, ia, ib, na, nb, rb, st;
    int ea, eb, e;
    longint unsigned n, d, qt, rm, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    lat = 1;
    f = 4'b0000;
    r = 32'h0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7fc00000;
      f = 4'b1000;
    end else if (zb) begin
      r = {s, 8'hff, 23'h0};
      if (!ia) f = 4'b0100;
    end else if (ia) begin
      r = {s, 8'hff, 23'h0};
    end else if (za || ib) begin
      r = {s, 31'h0};
    end else begin
      lat = 28;
      e  = ea - eb + 127;
      n  = {40'h0, 1'b1, a[22:0]} << 26;
      d  = {40'h0, 1'b1, b[22:0]};
      qt = n / d;
      rm = n % d;
      if (qt >= (64'd1 << 26)) begin
        mant = qt >> 3;
        rb = qt[2];
        st = (qt[1:0] != 0) || (rm != 0);
      end else begin
        mant = qt >> 2;
        rb = qt[1];
        st = qt[0] || (rm != 0);
        e = e - 1;
      end
      if (rb && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hff, 23'h0};
        f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0001;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [3:0] ef, input int el);
    int n;
    n = 0;
    @(negedge aclk);
    value1 = a;
    value2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{er, ef, el, cyc + 1});
    @(negedge aclk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: pops on every output handshake, sampled just after the falling edge.
  always begin
    @(negedge aclk);
    #1;
    if (!areset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output result=%h required=none", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
`ifdef FP_DIV_FLAGS_EN
        chk("flags", {28'h0, flags}, {28'h0, mon_e.flg});
`endif
        if (mon_e.lat >= 0) chk("latency", cyc + 1 - mon_e.acc, mon_e.lat);
      end
    end
  end

  logic [31:0] ra, rbv, er;
  logic [3:0]  ef;
  int          el;

  initial begin
    areset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    value1 = '0;
    value2 = '0;
    repeat (3) @(negedge aclk);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_result", result, 32'h0);
`ifdef FP_DIV_FLAGS_EN
    chk("rst_flags", {28'h0, flags}, 0);
`endif
    areset = 1'b0;

    send(32'h3fc00000, 32'h3fc00000, 32'h3f800000, 4'b0000, 28);
    send(32'hc0600000, 32'h40200000, 32'hbfb33333, 4'b0000, 28);
    send(32'h3f800000, 32'h40400000, 32'h3eaaaaab, 4'b0000, 28);
    send(32'h3f800000, 32'h00000000, 32'h7f800000, 4'b0100, 1);
    send(32'h00000000, 32'h00000000, 32'h7fc00000, 4'b1000, 1);
    send(32'h3f800000, 32'h7f800000, 32'h00000000, 4'b0000, 1);
    send(32'h7f7fffff, 32'h3f000000, 32'h7f800000, 4'b0010, 28);
    send(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28);
    drain();

    // Backpressure with a second request already waiting
    out_ready = 1'b0;
    send(32'hc0600000, 32'h40200000, 32'hbfb33333, 4'b0000, -1);
    fork
      send(32'h3f800000, 32'h40400000, 32'h3eaaaaab, 4'b0000, 28);
    join_none
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge aclk);
        n++;
      end
    end
    chk("bp_out_valid", {31'h0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("bp_result_hold", result, 32'hbfb33333);
      chk("bp_in_ready", {31'h0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(negedge aclk);
    chk("bp_release_out_valid", {31'h0, out_valid}, 0);
    chk("bp_release_in_ready", {31'h0, in_ready}, 1);
    @(negedge aclk);
    drain();

    // Reset in the middle of DIV
    send(32'h3fc00000, 32'h3fc00000, 32'h3f800000, 4'b0000, 28);
    repeat (9) @(negedge aclk);
    areset = 1'b1;
    sb.delete();
    @(negedge aclk);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_result", result, 32'h0);
    areset = 1'b0;
    send(32'hc0600000, 32'h40200000, 32'hbfb33333, 4'b0000, 28);
    drain();

    for (int i = 0; i < 150; i++) begin
      int k, eb;
      ra  = $urandom;
      rbv = $urandom;
      k   = $urandom_range(0, 9);
      if (k < 6) begin
        eb = int'(ra[30:23]) + int'($urandom_range(0, 80)) - 40;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        if (ra[30:23] == 8'h00 || ra[30:23] == 8'hff) ra[30:23] = 8'h80;
        rbv[30:23] = eb[7:0];
      end else if (k == 6) begin
        ra[30:23] = 8'h00;
      end else if (k == 7) begin
        rbv[30:23] = 8'hff;
        if ($urandom_range(0, 1) == 1) rbv[22:0] = 23'h0;
      end else if (k == 8) begin
        ra[30:23] = 8'hff;
        if ($urandom_range(0, 1) == 1) ra[22:0] = 23'h0;
      end
      model(ra, rbv, er, ef, el);
      send(ra, rbv, er, ef, el);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Parametrised IEEE-754-style floating-point divider: result = value1 / value2.
- Iterative radix-2 restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on input and output; one operation in flight.
- Successor to the single-precision divide path. Used by the fp_operation datapath wherever divide latency is acceptable and area matters.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored mantissa width, hidden bit excluded. Word width W = 1+EXP_W+MAN_W.
- BIAS, 2**(EXP_W-1)-1: exponent bias.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- areset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- value1  in  W  dividend.
- value2  in  W  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  quotient.
- flags  out  4  {invalid, divzero, overflow, underflow}; present only with FP_DIV_FLAGS_EN.

Behaviour:
- Reset values: state=IDLE; in_ready=1; out_valid=0; result=0; flags=0. A reset mid-operation abandons the operation, and the block is in IDLE on the following cycle.
- States: IDLE, DIV, ROUND, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Input capture: on the edge where in_valid&&in_ready, operands are unpacked and classified. Subnormal inputs are flushed to signed zero. Result sign = s1^s2 for all non-NaN results.
- Special operands go IDLE->DONE directly, with latency 1 (out_valid high the cycle after acceptance):
  - any NaN, 0/0, or inf/inf -> canonical qNaN: sign 0, exponent all ones, mantissa MSB 1. Sets invalid.
  - finite nonzero/0 -> signed inf. Sets divzero.
  - inf/finite -> signed inf.
  - 0/nonzero or finite/inf -> signed zero.
- Normal path, IDLE->DIV:
  - Exponent: e = e1 - e2 + BIAS, held in an EXP_W+2-bit signed register.
  - Mantissas: m1 and m2 are each MAN_W+1 bits with the hidden 1.
  - Remainder starts at m1.
- DIV: runs exactly MAN_W+3 cycles, produced by a counter.
  - Each cycle: if rem >= m2, then q bit=1 and rem -= m2; rem <<= 1.
  - Yields a quotient of 1 integer bit + MAN_W+2 fraction bits.
  - Then moves to ROUND.
- ROUND, single cycle:
  - Normalise: if q MSB=0, shift q left 1 and decrement e.
  - Sticky = OR of the bits below the round bit, plus (rem != 0).
  - Rounding is round-to-nearest-even.
  - A mantissa carry-out shifts the mantissa and increments e.
  - e >= 2**EXP_W-1 -> signed inf, sets overflow.
  - e <= 0 -> signed zero (flush), sets underflow.
  - Then moves to DONE.
- Normal-path latency: out_valid high MAN_W+5 cycles after the accepting edge (28 cycles at defaults).
- DONE: result and flags are held stable while out_ready=0. On out_valid&&out_ready, go to IDLE and drop out_valid. in_ready returns 1 the next cycle; there is no bypass from DONE to accept.
- Input changes while not in IDLE are ignored. in_valid held high across an operation is accepted only after return to IDLE.
- result is registered; it is updated only on entry to DONE.

Optional Feature:
- Macro: FP_DIV_FLAGS_EN.
- Defined: the flags port exists. Flags are registered on entry to DONE, held through DONE, and cleared on output handshake and on reset.
- Undefined: no flags port and no flag logic. The result encoding is identical in both builds.

Test Plan:
- 1.5/1.5: value1=value2=32'h3fc00000 -> result 32'h3f800000, out_valid exactly 28 cycles after acceptance, flags 0.
- -3.5/2.5: 32'hc0600000 / 32'h40200000 -> result 32'hbfb33333. Also 1/3: 32'h3f800000 / 32'h40400000 -> 32'h3eaaaaab, which checks RNE round-up.
- Specials:
  - 32'h3f800000 / 0 -> 32'h7f800000, divzero, latency 1.
  - 0/0 -> 32'h7fc00000, invalid.
  - 32'h3f800000 / 32'h7f800000 -> 32'h00000000.
- Overflow/underflow:
  - 32'h7f7fffff / 32'h3f000000 -> 32'h7f800000, overflow.
  - 32'h00800000 / 32'h40000000 -> 32'h00000000, underflow.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, no new acceptance. out_ready=1 -> IDLE next cycle, in_ready=1. Back-to-back in_valid yields a second correct result.
- Reset mid-DIV: assert areset at DIV cycle 10 -> the next cycle shows IDLE, out_valid=0, result=0. A fresh operation after reset completes correctly.
